// File: rtl/four_digit_led_pkg.sv
// Shared constants for the 4-digit LED driver: segment codes, message ROM
// contents, anode select patterns and the digit-index width.
package four_digit_led_pkg;

  localparam int DIGIT_W = 4;
  typedef logic [DIGIT_W-1:0] digit_t;
  typedef logic [1:0]         sel_t;

  // Active-low {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_A   = 7'b0001000;
  localparam logic [6:0] SEG_B   = 7'b1100000;
  localparam logic [6:0] SEG_C   = 7'b0110001;
  localparam logic [6:0] SEG_D   = 7'b1000010;
  localparam logic [6:0] SEG_E   = 7'b0110000;
  localparam logic [6:0] SEG_F   = 7'b0111000;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry i lives in nibble i
  localparam logic [63:0] MSG_ROM = 64'hFEDC_BA98_7654_3210;

  // {an3,an2,an1,an0}, active-low
  localparam logic [3:0] AN_DIG3 = 4'b0111;
  localparam logic [3:0] AN_DIG2 = 4'b1011;
  localparam logic [3:0] AN_DIG1 = 4'b1101;
  localparam logic [3:0] AN_DIG0 = 4'b1110;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  function automatic digit_t msg_char(input digit_t idx);
    return MSG_ROM[{idx, 2'b00} +: DIGIT_W];
  endfunction

  function automatic logic [6:0] seg_encode(input digit_t v);
    case (v)
      4'h0: return SEG_0;
      4'h1: return SEG_1;
      4'h2: return SEG_2;
      4'h3: return SEG_3;
      4'h4: return SEG_4;
      4'h5: return SEG_5;
      4'h6: return SEG_6;
      4'h7: return SEG_7;
      4'h8: return SEG_8;
      4'h9: return SEG_9;
      4'hA: return SEG_A;
      4'hB: return SEG_B;
      4'hC: return SEG_C;
      4'hD: return SEG_D;
      4'hE: return SEG_E;
      default: return SEG_F;
    endcase
  endfunction

  function automatic logic [3:0] anode_pattern(input sel_t sel);
    case (sel)
      2'd0: return AN_DIG3;
      2'd1: return AN_DIG2;
      2'd2: return AN_DIG1;
      default: return AN_DIG0;
    endcase
  endfunction

endpackage

// File: rtl/led_debouncer.sv
// Push-button conditioning: two-flop synchronizer, debounce counter and a
// one-cycle pulse on each debounced press (0->1 of the stable value).
module led_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = button;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    press_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/four_digit_led_driver.sv
// Multiplexed 4-digit common-anode display scrolling a 16-char hex message.
// Define AUTO_SCROLL_EN to add a free-running scroll timer alongside the button.
module four_digit_led_driver
  import four_digit_led_pkg::*;
#(
  parameter int REFRESH_CYCLES  = 16,
  parameter int DEBOUNCE_CYCLES = 16
`ifdef AUTO_SCROLL_EN
  , parameter int SCROLL_CYCLES = 1024
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

  logic          press;
  logic          step;
  logic          slot_end;
  digit_t        ptr_q, ptr_d;
  digit_t        disp_ptr_q, disp_ptr_d;
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  sel_t          sel_q, sel_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;

  led_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk   (clk),
    .rst_n (reset),
    .button(button),
    .press (press)
  );

`ifdef AUTO_SCROLL_EN
  localparam int SW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  logic [SW-1:0] scroll_cnt_q, scroll_cnt_d;
  logic          tick;

  always_comb begin
    tick         = (scroll_cnt_q == SW'(SCROLL_CYCLES - 1));
    scroll_cnt_d = tick ? '0 : scroll_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) scroll_cnt_q <= '0;
    else        scroll_cnt_q <= scroll_cnt_d;
  end

  // A coincident press and tick still advance by only one
  assign step = press | tick;
`else
  assign step = press;
`endif

  // The pointer seen by the display is sampled at slot boundaries so a
  // scroll never changes the character of a digit mid-slot.
  always_comb begin
    slot_end   = (ref_cnt_q == RW'(REFRESH_CYCLES - 1));
    ptr_d      = step ? ptr_q + 1'b1 : ptr_q;
    ref_cnt_d  = slot_end ? '0 : ref_cnt_q + 1'b1;
    sel_d      = slot_end ? sel_q + 1'b1 : sel_q;
    disp_ptr_d = slot_end ? ptr_q : disp_ptr_q;
    an_d       = anode_pattern(sel_q);
    seg_d      = seg_encode(msg_char(disp_ptr_q + digit_t'(sel_q)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q      <= '0;
      disp_ptr_q <= '0;
      ref_cnt_q  <= '0;
      sel_q      <= '0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      ptr_q      <= ptr_d;
      disp_ptr_q <= disp_ptr_d;
      ref_cnt_q  <= ref_cnt_d;
      sel_q      <= sel_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign {an3, an2, an1, an0}  = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;
  assign dp                    = 1'b1;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Directed bench for four_digit_led_driver: refresh order, debounced scrolling,
// glitch rejection, long hold and asynchronous reset.
module tb_four_digit_led_driver;

  logic clk = 1'b0;
  logic reset;
  logic button;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g;
  logic dp;
  logic [3:0] an_bus;
  logic [6:0] seg_bus;

  int checks = 0;
  int errors = 0;

  four_digit_led_driver #(
    .REFRESH_CYCLES (16),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .an3   (an3),
    .an2   (an2),
    .an1   (an1),
    .an0   (an0),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .dp    (dp)
  );

  always #10 clk = ~clk;

  assign an_bus  = {an3, an2, an1, an0};
  assign seg_bus = {a, b, c, d, e, f, g};

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] seg_ref(input int v);
    case (v)
      0:  return 7'b0000001;
      1:  return 7'b1001111;
      2:  return 7'b0010010;
      3:  return 7'b0000110;
      4:  return 7'b1001100;
      5:  return 7'b0100100;
      6:  return 7'b0100000;
      7:  return 7'b0001111;
      8:  return 7'b0000000;
      9:  return 7'b0000100;
      10: return 7'b0001000;
      11: return 7'b1100000;
      12: return 7'b0110001;
      13: return 7'b1000010;
      14: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [3:0] an_ref(input int s);
    case (s)
      0: return 4'b0111;
      1: return 4'b1011;
      2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_anode(input logic [3:0] pat);
    for (int i = 0; i < 200; i++) begin
      if (an_bus == pat) break;
      cyc(1);
    end
  endtask

  // Checks every slot shows the expected character for scroll position p
  task automatic check_display(input int p, input string tag);
    for (int s = 0; s < 4; s++) begin
      wait_anode(an_ref(s));
      chk_eq($sformatf("%s_an_slot%0d", tag, s), 32'(an_bus), 32'(an_ref(s)));
      chk_eq($sformatf("%s_seg_slot%0d", tag, s), 32'(seg_bus), 32'(seg_ref((p + s) % 16)));
    end
  endtask

  task automatic press(input int hi);
    button = 1'b1;
    cyc(hi);
    button = 1'b0;
    cyc(100);
  endtask

  initial begin
    reset  = 1'b0;
    button = 1'b0;
    #55;
    chk_eq("rst_an", 32'(an_bus), 32'hF);
    chk_eq("rst_seg", 32'(seg_bus), 32'h7F);
    chk_eq("rst_dp", 32'(dp), 32'h1);

    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk_eq("start_an3", 32'(an_bus), 32'(4'b0111));
    chk_eq("start_seg0", 32'(seg_bus), 32'(7'b0000001));
    cyc(15);
    chk_eq("hold_an3", 32'(an_bus), 32'(4'b0111));
    cyc(1);
    chk_eq("step_an2", 32'(an_bus), 32'(4'b1011));
    chk_eq("step_seg1", 32'(seg_bus), 32'(7'b1001111));
    cyc(16);
    chk_eq("step_an1", 32'(an_bus), 32'(4'b1101));
    chk_eq("step_seg2", 32'(seg_bus), 32'(7'b0010010));
    cyc(16);
    chk_eq("step_an0", 32'(an_bus), 32'(4'b1110));
    chk_eq("step_seg3", 32'(seg_bus), 32'(7'b0000110));
    cyc(16);
    chk_eq("wrap_an3", 32'(an_bus), 32'(4'b0111));
    chk_eq("wrap_seg0", 32'(seg_bus), 32'(7'b0000001));

    press(10);
    check_display(0, "glitch");

    press(20);
    check_display(1, "press1");

    for (int k = 0; k < 12; k++) press(20);
    check_display(13, "press13");

    press(10000);
    check_display(14, "hold");

    wait_anode(4'b1101);
    #5;
    reset = 1'b0;
    #1;
    chk_eq("async_rst_an", 32'(an_bus), 32'hF);
    chk_eq("async_rst_seg", 32'(seg_bus), 32'h7F);
    cyc(3);
    chk_eq("held_rst_an", 32'(an_bus), 32'hF);
    @(negedge clk);
    reset = 1'b1;
    cyc(1);
    chk_eq("restart_an3", 32'(an_bus), 32'(4'b0111));
    chk_eq("restart_seg0", 32'(seg_bus), 32'(7'b0000001));
    check_display(0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
